// File: rtl/dnn_acc_axi_sram_if.sv
// dnn_acc_axi_sram_if: 64-bit AXI3 bus between the accelerator master and the SRAM slave
interface dnn_acc_axi_sram_if;
  logic [31:0] araddr;
  logic [1:0] arburst;
  logic arid;
  logic [3:0] arlen;
  logic [2:0] arsize;
  logic [3:0] arcache;
  logic arvalid;
  logic arready;
  logic [31:0] awaddr;
  logic [1:0] awburst;
  logic awid;
  logic [3:0] awlen;
  logic [2:0] awsize;
  logic [3:0] awcache;
  logic awvalid;
  logic awready;
  logic [63:0] rdata;
  logic rid;
  logic rlast;
  logic [1:0] rresp;
  logic rvalid;
  logic rready;
  logic [63:0] wdata;
  logic wlast;
  logic [7:0] wstrb;
  logic wvalid;
  logic wready;
  logic bid;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  modport master (
    output araddr, arburst, arid, arlen, arsize, arcache, arvalid,
    input arready,
    output awaddr, awburst, awid, awlen, awsize, awcache, awvalid,
    input awready,
    input rdata, rid, rlast, rresp, rvalid,
    output rready,
    output wdata, wlast, wstrb, wvalid,
    input wready,
    input bid, bresp, bvalid,
    output bready
  );
  modport slave (
    input araddr, arburst, arid, arlen, arsize, arcache, arvalid,
    output arready,
    input awaddr, awburst, awid, awlen, awsize, awcache, awvalid,
    output awready,
    output rdata, rid, rlast, rresp, rvalid,
    input rready,
    input wdata, wlast, wstrb, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input bready
  );
endinterface

// File: rtl/dnn_acc_axi_sram.sv
// dnn_acc_axi_sram: AXI3 slave on a 64-bit word SRAM; DNN_ACC_SRAM_RANGE_CHECK_EN enables the start-address range check
module dnn_acc_axi_sram #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int MEM_DEPTH_LOG2 = 12
) (
  input logic user_clk,
  input logic user_reset,
  dnn_acc_axi_sram_if.slave user_axi
);
  localparam int D = MEM_DEPTH_LOG2;
  typedef enum logic [1:0] {IDLE, RD_BURST, WR_DATA, WR_RESP} state_t;
  state_t state_q, state_d;
  logic prio_q, prio_d, id_q, id_d, err_q, err_d;
  logic [D-1:0] idx_q, idx_d, idx_nxt;
  logic [3:0] beat_q, beat_d, len_q, len_d;
  logic [1:0] burst_q, burst_d;
  logic [31:0] aw_off, ar_off;
  logic aw_err, ar_err, aw_hs, ar_hs, r_hs, w_hs, beat_last, we;
  logic [63:0] mem [0:(1<<D)-1];
  logic unused_ok;
  assign aw_off = user_axi.awaddr - ADDR_BASE;
  assign ar_off = user_axi.araddr - ADDR_BASE;
`ifdef DNN_ACC_SRAM_RANGE_CHECK_EN
  assign aw_err = |(aw_off >> (D + 3));
  assign ar_err = |(ar_off >> (D + 3));
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif
  // readies are held low while reset is applied so no handshake lands in a reset cycle
  assign user_axi.awready = state_q == IDLE && !user_reset && (!user_axi.arvalid || !prio_q);
  assign user_axi.arready = state_q == IDLE && !user_reset && (!user_axi.awvalid || prio_q);
  assign user_axi.wready = state_q == WR_DATA && !user_reset;
  assign user_axi.rvalid = state_q == RD_BURST;
  assign user_axi.bvalid = state_q == WR_RESP;
  assign aw_hs = user_axi.awvalid && user_axi.awready;
  assign ar_hs = user_axi.arvalid && user_axi.arready;
  assign w_hs = user_axi.wvalid && user_axi.wready;
  assign r_hs = user_axi.rvalid && user_axi.rready;
  assign we = w_hs && !err_q;
  assign beat_last = beat_q == len_q;
  assign idx_nxt = burst_q == 2'b00 ? idx_q : idx_q + 1'b1;
  assign user_axi.rdata = user_axi.rvalid && !err_q ? mem[idx_q] : 64'd0;
  assign user_axi.rid = user_axi.rvalid && id_q;
  assign user_axi.rlast = user_axi.rvalid && beat_last;
  assign user_axi.rresp = user_axi.rvalid && err_q ? 2'b10 : 2'b00;
  assign user_axi.bid = user_axi.bvalid && id_q;
  assign user_axi.bresp = user_axi.bvalid && err_q ? 2'b10 : 2'b00;
  assign unused_ok = ^{user_axi.arsize, user_axi.arcache, user_axi.awsize, user_axi.awcache,
                       user_axi.wlast, aw_off, ar_off};
  always_comb begin
    state_d = state_q;
    prio_d = prio_q;
    idx_d = idx_q;
    beat_d = beat_q;
    len_d = len_q;
    burst_d = burst_q;
    id_d = id_q;
    err_d = err_q;
    if (aw_hs) begin
      state_d = WR_DATA;
      prio_d = !prio_q;
      idx_d = aw_off[D+2:3];
      beat_d = 4'd0;
      len_d = user_axi.awlen;
      burst_d = user_axi.awburst;
      id_d = user_axi.awid;
      err_d = aw_err;
    end else if (ar_hs) begin
      state_d = RD_BURST;
      prio_d = !prio_q;
      idx_d = ar_off[D+2:3];
      beat_d = 4'd0;
      len_d = user_axi.arlen;
      burst_d = user_axi.arburst;
      id_d = user_axi.arid;
      err_d = ar_err;
    end
    if (r_hs || w_hs) begin
      beat_d = beat_q + 4'd1;
      idx_d = idx_nxt;
    end
    if (r_hs && beat_last) state_d = IDLE;
    if (w_hs && beat_last) state_d = WR_RESP;
    if (user_axi.bvalid && user_axi.bready) state_d = IDLE;
  end
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_q <= IDLE;
      prio_q <= 1'b0;
      idx_q <= '0;
      beat_q <= 4'd0;
      len_q <= 4'd0;
      burst_q <= 2'b00;
      id_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q <= prio_d;
      idx_q <= idx_d;
      beat_q <= beat_d;
      len_q <= len_d;
      burst_q <= burst_d;
      id_q <= id_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge user_clk) begin
    if (we)
      for (int k = 0; k < 8; k++)
        if (user_axi.wstrb[k]) mem[idx_q][8*k +: 8] <= user_axi.wdata[8*k +: 8];
  end
endmodule

// File: tb/tb_dnn_acc_axi_sram.sv
// tb_dnn_acc_axi_sram: directed checks of bursts, strobes, arbitration, backpressure, reset and range handling
module tb_dnn_acc_axi_sram;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [63:0] wbuf [0:7];
  logic [63:0] rbuf [0:7];
  dnn_acc_axi_sram_if ax();
  dnn_acc_axi_sram dut (.user_clk(clk), .user_reset(rst), .user_axi(ax));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic aw_req(input logic [31:0] a, input logic [1:0] b, input logic [3:0] l, input logic id);
    int n = 0;
    ax.awaddr = a; ax.awburst = b; ax.awlen = l; ax.awid = id; ax.awvalid = 1'b1;
    #1;
    while (!ax.awready && n < 20) begin tick; n++; end
    chk("aw_grant", ax.awready, 1);
    tick;
    ax.awvalid = 1'b0;
  endtask
  task automatic ar_req(input logic [31:0] a, input logic [1:0] b, input logic [3:0] l, input logic id);
    int n = 0;
    ax.araddr = a; ax.arburst = b; ax.arlen = l; ax.arid = id; ax.arvalid = 1'b1;
    #1;
    while (!ax.arready && n < 20) begin tick; n++; end
    chk("ar_grant", ax.arready, 1);
    tick;
    ax.arvalid = 1'b0;
  endtask
  task automatic w_beats(input int len, input logic [7:0] strb, input logic [1:0] eresp, input logic eid);
    for (int i = 0; i <= len; i++) begin
      ax.wvalid = 1'b1; ax.wdata = wbuf[i]; ax.wstrb = strb; ax.wlast = (i == len);
      #1;
      chk("w_ready", ax.wready, 1);
      chk("w_bvalid_early", ax.bvalid, 0);
      tick;
    end
    ax.wvalid = 1'b0; ax.wlast = 1'b0;
    chk("b_valid", ax.bvalid, 1);
    chk("b_resp", ax.bresp, eresp);
    chk("b_id", ax.bid, eid);
    ax.bready = 1'b1;
    tick;
    ax.bready = 1'b0;
    #1;
    chk("b_done", ax.bvalid, 0);
  endtask
  task automatic r_beats(input int len, input bit toggle, input logic eid, input logic [1:0] eresp);
    for (int i = 0; i <= len; i++) begin
      if (toggle) begin
        ax.rready = 1'b0;
        #1;
        chk("r_stall_valid", ax.rvalid, 1);
        chk("r_stall_data", ax.rdata, rbuf[i]);
        tick;
        chk("r_hold_data", ax.rdata, rbuf[i]);
        chk("r_hold_last", ax.rlast, i == len);
      end
      ax.rready = 1'b1;
      #1;
      chk("r_valid", ax.rvalid, 1);
      chk("r_data", ax.rdata, rbuf[i]);
      chk("r_last", ax.rlast, i == len);
      chk("r_id", ax.rid, eid);
      chk("r_resp", ax.rresp, eresp);
      tick;
    end
    ax.rready = 1'b0;
    #1;
    chk("r_done", ax.rvalid, 0);
  endtask
  initial begin
    ax.araddr = '0; ax.arburst = 2'b01; ax.arid = 0; ax.arlen = 0; ax.arsize = 3'd3; ax.arcache = 0; ax.arvalid = 0;
    ax.awaddr = '0; ax.awburst = 2'b01; ax.awid = 0; ax.awlen = 0; ax.awsize = 3'd3; ax.awcache = 0; ax.awvalid = 0;
    ax.rready = 0; ax.wdata = '0; ax.wlast = 0; ax.wstrb = '0; ax.wvalid = 0; ax.bready = 0;
    tick; tick;
    chk("rst_awready", ax.awready, 0);
    chk("rst_arready", ax.arready, 0);
    chk("rst_wready", ax.wready, 0);
    chk("rst_rvalid", ax.rvalid, 0);
    chk("rst_bvalid", ax.bvalid, 0);
    chk("rst_rdata", ax.rdata, 0);
    chk("rst_bresp", ax.bresp, 0);
    rst = 1'b0;
    tick;
    // simultaneous AW/AR after reset: write wins, then read wins
    ax.awaddr = 32'h100; ax.awburst = 2'b01; ax.awlen = 4'd3; ax.awid = 1'b1;
    ax.araddr = 32'h100; ax.arburst = 2'b01; ax.arlen = 4'd3; ax.arid = 1'b0;
    ax.awvalid = 1'b1; ax.arvalid = 1'b1;
    #1;
    chk("arb_aw_first", ax.awready, 1);
    chk("arb_ar_blocked", ax.arready, 0);
    tick;
    ax.awvalid = 1'b0;
    wbuf[0] = 64'h1111_1111_1111_1111; wbuf[1] = 64'h2222_2222_2222_2222;
    wbuf[2] = 64'h3333_3333_3333_3333; wbuf[3] = 64'h4444_4444_4444_4444;
    w_beats(3, 8'hFF, 2'b00, 1'b1);
    ax.awaddr = 32'h200; ax.awvalid = 1'b1;
    #1;
    chk("arb_ar_second", ax.arready, 1);
    chk("arb_aw_blocked", ax.awready, 0);
    tick;
    ax.arvalid = 1'b0; ax.awvalid = 1'b0;
    for (int i = 0; i < 4; i++) rbuf[i] = wbuf[i];
    r_beats(3, 1'b0, 1'b0, 2'b00);
    wbuf[0] = 64'd0;
    aw_req(32'h300, 2'b01, 4'd0, 1'b0);
    w_beats(0, 8'hFF, 2'b00, 1'b0);
    wbuf[0] = 64'hAABB_CCDD_EEFF_0011;
    aw_req(32'h300, 2'b01, 4'd0, 1'b1);
    w_beats(0, 8'h0F, 2'b00, 1'b1);
    rbuf[0] = 64'h0000_0000_EEFF_0011;
    ar_req(32'h300, 2'b01, 4'd0, 1'b1);
    r_beats(0, 1'b0, 1'b1, 2'b00);
    for (int i = 0; i < 8; i++) wbuf[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
    aw_req(32'h400, 2'b01, 4'd7, 1'b0);
    w_beats(7, 8'hFF, 2'b00, 1'b0);
    for (int i = 0; i < 8; i++) rbuf[i] = wbuf[i];
    ar_req(32'h400, 2'b01, 4'd7, 1'b0);
    r_beats(7, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) rbuf[i] = 64'hC0DE_0000_0000_0001;
    ar_req(32'h408, 2'b00, 4'd3, 1'b1);
    r_beats(3, 1'b0, 1'b1, 2'b00);
    // reset on the second beat of a len-7 write; beat 0 must survive
    aw_req(32'h500, 2'b01, 4'd7, 1'b1);
    ax.wvalid = 1'b1; ax.wdata = 64'h5050_5050_5050_5050; ax.wstrb = 8'hFF;
    tick;
    ax.wdata = 64'h6060_6060_6060_6060;
    rst = 1'b1;
    tick;
    ax.wvalid = 1'b0;
    chk("mid_rst_wready", ax.wready, 0);
    chk("mid_rst_bvalid", ax.bvalid, 0);
    chk("mid_rst_rvalid", ax.rvalid, 0);
    chk("mid_rst_bid", ax.bid, 0);
    chk("mid_rst_rdata", ax.rdata, 0);
    rst = 1'b0;
    wbuf[0] = 64'h7070_7070_7070_7070;
    aw_req(32'h508, 2'b01, 4'd0, 1'b0);
    w_beats(0, 8'hFF, 2'b00, 1'b0);
    rbuf[0] = 64'h5050_5050_5050_5050; rbuf[1] = 64'h7070_7070_7070_7070;
    ar_req(32'h500, 2'b01, 4'd1, 1'b1);
    r_beats(1, 1'b0, 1'b1, 2'b00);
    wbuf[0] = 64'h5555_5555_5555_5555;
    aw_req(32'h0, 2'b01, 4'd0, 1'b0);
    w_beats(0, 8'hFF, 2'b00, 1'b0);
    wbuf[0] = 64'hDEAD_BEEF_DEAD_BEEF;
    aw_req(32'h8000, 2'b01, 4'd0, 1'b1);
`ifdef DNN_ACC_SRAM_RANGE_CHECK_EN
    w_beats(0, 8'hFF, 2'b10, 1'b1);
    rbuf[0] = 64'd0;
    ar_req(32'h8000, 2'b01, 4'd0, 1'b0);
    r_beats(0, 1'b0, 1'b0, 2'b10);
    rbuf[0] = 64'h5555_5555_5555_5555;
`else
    w_beats(0, 8'hFF, 2'b00, 1'b1);
    rbuf[0] = 64'hDEAD_BEEF_DEAD_BEEF;
`endif
    ar_req(32'h0, 2'b01, 4'd0, 1'b0);
    r_beats(0, 1'b0, 1'b0, 2'b00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dnn_acc_axi_sram.md
# dnn_acc_axi_sram

AXI3 slave that terminates the DNN accelerator's 64-bit AXI master port on a local single-port word SRAM. Sits directly downstream of the accelerator top and connects port-for-port to its `user_axi_*` bus. Serves one read or write burst at a time, with fair arbitration between the read and write channels. Gives the accelerator a deterministic, zero-wait-state memory for bring-up and simulation.

## Interface
- `ADDR_BASE`, default 32'h0000_0000: byte address of SRAM word 0.
- `MEM_DEPTH_LOG2`, default 12: SRAM depth is 2^MEM_DEPTH_LOG2 words of 64 bits (32 KiB).
- `user_clk`  in  1  sole clock; all logic samples on the rising edge.
- `user_reset`  in  1  synchronous, active-high reset.
- `user_axi_araddr/arburst/arid/arlen/arsize/arcache`  in  32/2/1/4/3/4  read address channel.
- `user_axi_arvalid` in 1; `user_axi_arready` out 1.
- `user_axi_awaddr/awburst/awid/awlen/awsize/awcache`  in  32/2/1/4/3/4  write address channel.
- `user_axi_awvalid` in 1; `user_axi_awready` out 1.
- `user_axi_rdata/rid/rlast/rresp/rvalid`  out  64/1/1/2/1; `user_axi_rready` in 1.
- `user_axi_wdata/wlast/wstrb/wvalid`  in  64/1/8/1; `user_axi_wready` out 1.
- `user_axi_bid/bresp/bvalid`  out  1/2/1; `user_axi_bready` in 1.

## Operation
- FSM states: IDLE, RD_BURST, WR_DATA, WR_RESP. Reset state is IDLE.
- Arbitration uses a priority flag `prio` (0 = write first). Reset value is 0.
  - `awready = IDLE && (!arvalid || prio==0)`.
  - `arready = IDLE && (!awvalid || prio==1)`.
  - The two handshakes never occur in the same cycle.
  - `prio` flips each time an AR or AW handshake occurs.
- Address handshake latches the address, ID, `len` and `burst`.
  - Word index = (addr − ADDR_BASE) >> 3, truncated to MEM_DEPTH_LOG2 bits. Address bits [2:0] are ignored.
  - `arsize`/`awsize` and `cache` are ignored; every beat is 8 bytes.
  - Beat counter is cleared to 0.
- Burst address update per accepted beat:
  - FIXED (2'b00): index held.
  - INCR (2'b01) and WRAP (2'b10, treated as INCR): index + 1, wrapping modulo 2^MEM_DEPTH_LOG2.
  - Reserved (2'b11): treated as INCR.
- Read bursts (RD_BURST):
  - `rvalid` = 1; `rdata` = mem[index] via combinational read from the registered index.
  - `rid` = latched ARID; `rlast` = (beat == len).
  - On `rvalid && rready`: advance the beat. If it was the last beat, go to IDLE.
- Write bursts (WR_DATA):
  - `wready` = 1.
  - On `wvalid && wready`: write byte lane k of mem[index] iff `wstrb[k]`, then advance the beat.
  - When beat == len on that accept, go to WR_RESP.
  - `wlast` is not checked; the beat count alone ends the burst.
- Write response (WR_RESP): `bvalid` = 1, `bid` = latched AWID, `bresp` = OKAY. On `bready`, go to IDLE.
- Outside RD_BURST: `rdata`, `rid`, `rlast` and `rresp` are driven to 0.
- Outside WR_RESP: `bid` and `bresp` are driven to 0.

## Timing
- Reset values: all ready and valid outputs 0; `rdata`, `rid`, `rlast`, `rresp`, `bid`, `bresp` all 0; `prio` = 0; state IDLE.
- SRAM contents are not reset.
- Read latency: AR handshake in cycle N, beat 0 valid in N+1. With `rready` held high, one beat per cycle.
- Write: AW handshake in cycle N, `wready` high from N+1, one beat per cycle. After the last W beat in cycle M, `bvalid` rises in M+1.
- Return to IDLE the cycle after the last R beat or the B handshake. The next address handshake is possible in that IDLE cycle (one dead cycle between bursts).
- Backpressure: while `rready` = 0, `rvalid`/`rdata`/`rlast` hold stable. While `wvalid` = 0, no write occurs and the index holds.
- `user_reset` asserted mid-burst: next cycle is IDLE with all outputs at reset values. The in-flight burst is dropped. SRAM writes already performed remain.

## Configuration
- Macro: `DNN_ACC_SRAM_RANGE_CHECK_EN`.
- Defined:
  - The burst start address is checked against [ADDR_BASE, ADDR_BASE + 8·2^MEM_DEPTH_LOG2).
  - If out of range, the burst completes with normal beat timing, but writes are suppressed, `bresp` = SLVERR (2'b10), every R beat has `rresp` = SLVERR, and `rdata` = 0.
  - Beats that cross the top of the range after an in-range start are not checked; they wrap.
- Undefined: no check; all addresses alias modulo SRAM size; `rresp`/`bresp` are always OKAY.

## Test plan
- INCR write at 0x100, len 3, data 0x11..11 to 0x44..44, `wstrb` 0xFF → `bvalid` one cycle after the 4th beat, bresp 0. Then an INCR read at 0x100, len 3 → beats 0x11..11 to 0x44..44 in consecutive cycles, `rlast` on beat 3 only.
- Partial strobe: write 0xAABBCCDD_EEFF0011 with `wstrb` 0x0F over a word holding 0 → readback 0x00000000_EEFF0011.
- `awvalid` and `arvalid` asserted in the same cycle after reset → write granted first. With both re-asserted after it finishes, the read is granted.
- Read len 7 with `rready` toggling every cycle → exactly 8 beats with correct data and `rdata` stable while stalled. FIXED read len 3 → the same word returned four times.
- Reset asserted on the 2nd beat of a len-7 write → all outputs 0 next cycle, state IDLE, `awready` = 1 when `awvalid` is next presented.
- With `DNN_ACC_SRAM_RANGE_CHECK_EN` and MEM_DEPTH_LOG2 = 12: write at 0x8000 → bresp 2'b10 and memory unchanged. Without the macro: the same write lands at word 0, bresp 0.
